// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: the pipeline's register addresses and write
// enables in, stall/flush/forward controls back out.
interface hazard_ctrl_if;
  logic [3:0] RA1D, RA2D;
  logic [3:0] RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE;
  logic       PCSrcD;
  logic       BranchTakenE;
  logic       StallF, StallD;
  logic       FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;

  modport master (
    output RA1D, RA2D, RA1E, RA2E,
    output WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE, PCSrcD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E,
    input  WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE, PCSrcD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, R15-write drain, branch flush,
// E-stage forwarding and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_clr,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  logic [1:0]       pend_q, pend_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             ldstall, pc_acc;
  logic             stl_f, stl_d, fl_d, fl_e;
  logic [1:0]       fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       we_m,
    input logic [3:0] wa_m,
    input logic       we_w,
    input logic [3:0] wa_w
  );
    logic [1:0] s;
    s = 2'b00;
    if (ra != 4'd15) begin
      if (we_m && wa_m == ra)      s = 2'b10;
      else if (we_w && wa_w == ra) s = 2'b01;
    end
    return s;
  endfunction

  // Hazard detection, R15 drain counter next state and raw controls
  always_comb begin
    ldstall = hz.MemtoRegE & hz.RegWriteE &
              ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));
    pc_acc  = hz.PCSrcD & ~ldstall & ~hz.BranchTakenE &
              (pend_q == 2'd0);
    pend_d  = 2'd0;
    if (pc_acc)              pend_d = 2'd3;
    else if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
    stl_f = ldstall | pc_acc | (pend_q >= 2'd2);
    stl_d = ldstall;
    fl_d  = pc_acc | (pend_q != 2'd0) | hz.BranchTakenE;
    fl_e  = ldstall | hz.BranchTakenE;
    fwd_a = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M,
                    hz.RegWriteW, hz.WA3W);
    fwd_b = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M,
                    hz.RegWriteW, hz.WA3W);
  end

  // Saturating event counter next state; clear wins over count
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stl_d && stall_q != '1) stall_d = stall_q + 1'b1;
      if (fl_e && flush_q != '1)  flush_d = flush_q + 1'b1;
    end
  end

  // State registers; reset drops any pending R15 write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Outputs; while in reset, flush both registers and stall nothing
  always_comb begin
    hz.StallF    = reset & stl_f;
    hz.StallD    = reset & stl_d;
    hz.FlushD    = ~reset | fl_d;
    hz.FlushE    = ~reset | fl_e;
    hz.ForwardAE = reset ? fwd_a : 2'b00;
    hz.ForwardBE = reset ? fwd_b : 2'b00;
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with 4-bit counters: stalls, flushes,
// forwarding, R15 drain timing, reset and counter saturation.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [3:0] stall_cycles, flush_cycles;
  int         n_cmp = 0;
  int         n_bad = 0;

  hazard_ctrl_if hz();

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_clr      (cnt_clr),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  always #5 clk = ~clk;

  task automatic idle();
    hz.RA1D = 4'd1; hz.RA2D = 4'd2;
    hz.RA1E = 4'd3; hz.RA2E = 4'd6;
    hz.WA3E = 4'd0; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0;
    hz.RegWriteW = 1'b0; hz.MemtoRegE = 1'b0;
    hz.PCSrcD = 1'b0; hz.BranchTakenE = 1'b0;
  endtask

  task automatic set_load_use(input logic [3:0] ra1, ra2);
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1;
    hz.WA3E = 4'd4; hz.RA1D = ra1; hz.RA2D = ra2;
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got, want;
    idle();
    reset = 1'b0;
    #1;
    got  = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.ForwardAE};
    want = 6'b001100;
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want %b", got, want);
    end
    n_cmp++;
    if ({stall_cycles, flush_cycles} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h want 00",
               {stall_cycles, flush_cycles});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    got  = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.ForwardAE};
    n_cmp++;
    if (got !== 6'b000000 || hz.ForwardBE !== 2'b00) begin
      n_bad++;
      $display("FAIL post_reset_outs: got %b/%b want 000000/00",
               got, hz.ForwardBE);
    end
  endtask

  task automatic test_load_use();
    logic [3:0] got;
    clear_cnt();
    set_load_use(4'd4, 4'd2);
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b1101) begin
      n_bad++;
      $display("FAIL load_use_ra1: got %b want 1101", got);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (stall_cycles !== 4'd1 || flush_cycles !== 4'd1) begin
      n_bad++;
      $display("FAIL load_use_cnt: got %0d/%0d want 1/1",
               stall_cycles, flush_cycles);
    end
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_bad++;
      $display("FAIL load_use_drop: got %b want 0000", got);
    end
    set_load_use(4'd9, 4'd4);
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b1101) begin
      n_bad++;
      $display("FAIL load_use_ra2: got %b want 1101", got);
    end
    hz.MemtoRegE = 1'b0;
    #1;
    n_cmp++;
    if (hz.StallD !== 1'b0) begin
      n_bad++;
      $display("FAIL no_load_alu: got %b want 0", hz.StallD);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_forward();
    logic [3:0] got;
    idle();
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    hz.WA3M = 4'd5; hz.WA3W = 4'd5; hz.RA1E = 4'd5;
    #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b10) begin
      n_bad++;
      $display("FAIL fwd_a_m_prio: got %b want 10", hz.ForwardAE);
    end
    hz.RegWriteM = 1'b0;
    #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b01) begin
      n_bad++;
      $display("FAIL fwd_a_w: got %b want 01", hz.ForwardAE);
    end
    hz.RA1E = 4'd15; hz.WA3W = 4'd15; hz.WA3M = 4'd15;
    hz.RegWriteM = 1'b1;
    #1;
    n_cmp++;
    if (hz.ForwardAE !== 2'b00) begin
      n_bad++;
      $display("FAIL fwd_a_r15: got %b want 00", hz.ForwardAE);
    end
    hz.RA2E = 4'd7; hz.WA3M = 4'd7; hz.WA3W = 4'd3;
    #1;
    got = {hz.ForwardAE, hz.ForwardBE};
    n_cmp++;
    if (got !== 4'b0010) begin
      n_bad++;
      $display("FAIL fwd_b_m: got %b want 0010", got);
    end
    hz.WA3M = 4'd2; hz.WA3W = 4'd7; hz.RA1E = 4'd2;
    #1;
    got = {hz.ForwardAE, hz.ForwardBE};
    n_cmp++;
    if (got !== 4'b1001) begin
      n_bad++;
      $display("FAIL fwd_ab_mix: got %b want 1001", got);
    end
    idle();
  endtask

  task automatic test_pc_write();
    logic [4:0] pat [3];
    logic [4:0] exp_sf, exp_fd;
    logic [1:0] got;
    pat[0] = 5'b00001;
    pat[1] = 5'b00011;
    pat[2] = 5'b00101;
    exp_sf = 5'b00111;
    exp_fd = 5'b01111;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        hz.PCSrcD = pat[r][c];
        #1;
        got = {hz.StallF, hz.FlushD};
        n_cmp++;
        if (got !== {exp_sf[c], exp_fd[c]} || hz.FlushE !== 1'b0) begin
          n_bad++;
          $display("FAIL pc_write r%0d c%0d: got SF/FD/FE %b%b want %b%b0",
                   r, c, got, hz.FlushE, exp_sf[c], exp_fd[c]);
        end
      end
      @(negedge clk);
      idle();
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [3:0] got;
    clear_cnt();
    hz.BranchTakenE = 1'b1; hz.PCSrcD = 1'b1;
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b0011) begin
      n_bad++;
      $display("FAIL branch_pc: got %b want 0011", got);
    end
    @(negedge clk);
    idle();
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b0000 || flush_cycles !== 4'd1) begin
      n_bad++;
      $display("FAIL branch_after: got %b cnt %0d want 0000 cnt 1",
               got, flush_cycles);
    end
    set_load_use(4'd4, 4'd4);
    hz.BranchTakenE = 1'b1;
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b1111) begin
      n_bad++;
      $display("FAIL branch_ldstall: got %b want 1111", got);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    set_load_use(4'd4, 4'd1);
    @(negedge clk);
    idle();
    hz.PCSrcD = 1'b1;
    @(negedge clk);
    hz.PCSrcD = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_mid_outs: got %b want 0011", got);
    end
    n_cmp++;
    if ({stall_cycles, flush_cycles} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_cnt: got %h want 00",
               {stall_cycles, flush_cycles});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    got = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_mid_release: got %b want 0000", got);
    end
  endtask

  task automatic test_saturation();
    clear_cnt();
    set_load_use(4'd4, 4'd1);
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (stall_cycles !== 4'd15 || flush_cycles !== 4'd15) begin
      n_bad++;
      $display("FAIL saturate: got %0d/%0d want 15/15",
               stall_cycles, flush_cycles);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    n_cmp++;
    if (stall_cycles !== 4'd0 || flush_cycles !== 4'd0) begin
      n_bad++;
      $display("FAIL clr_prio: got %0d/%0d want 0/0",
               stall_cycles, flush_cycles);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (stall_cycles !== 4'd1) begin
      n_bad++;
      $display("FAIL recount: got %0d want 1", stall_cycles);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_pc_write();
    test_branch();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the stall, flush and forwarding controls of the Fetch, Decode and Execute stages, including the synchronous clear of the Decode→Execute pipeline register. It detects load-use and PC-write hazards and branch-taken redirects, and tracks in-flight PC writes with an internal counter. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4  source registers of the Decode-stage instruction
- RA1E, RA2E  in  4  source registers of the Execute-stage instruction
- WA3E, WA3M, WA3W  in  4  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in E/M/W
- MemtoRegE  in  1  Execute-stage instruction is a load
- PCSrcD  in  1  Decode-stage instruction writes R15
- BranchTakenE  in  1  branch resolved taken in Execute
- cnt_clr  in  1  synchronous clear of both performance counters
- StallF, StallD  out  1  hold the PC register / the F→D register
- FlushD, FlushE  out  1  clear the F→D register / the D→E register (clr)
- ForwardAE, ForwardBE  out  2  operand source select: 00 = register file, 01 = W result, 10 = M ALU result
- stall_cycles, flush_cycles  out  CNT_W  saturating event counters

## Operation
- ldstall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- pcD_acc = PCSrcD & ~ldstall & ~BranchTakenE & (pend_cnt==0). A PC write in a stalled or flushed Decode slot is not accepted. PCSrcD while pend_cnt!=0 is ignored.
- pend_cnt: 2-bit counter.
  - Loads 3 on pcD_acc.
  - Otherwise decrements when nonzero.
  - Values 3/2/1 mean the R15 writer is in E/M/W.
- Outputs:
  - StallF = ldstall | pcD_acc | pend_cnt>=2
  - StallD = ldstall
  - FlushD = pcD_acc | pend_cnt!=0 | BranchTakenE
  - FlushE = ldstall | BranchTakenE
- Forwarding (A shown; B identical with RA2E):
  - ForwardAE = 10 if RegWriteM & WA3M==RA1E & RA1E!=15.
  - Else 01 if RegWriteW & WA3W==RA1E & RA1E!=15.
  - Else 00.
  - M has priority over W.
- Counters:
  - stall_cycles += 1 each cycle StallD=1.
  - flush_cycles += 1 each cycle FlushE=1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.
- Simultaneous events:
  - BranchTakenE with ldstall: both FlushD and FlushE assert, and StallD asserts. The stall takes precedence at the F→D register, which holds; the flush is redundant there because the held instruction is on the wrong path and is re-flushed by the redirect.
  - BranchTakenE while pend_cnt!=0: the counter keeps counting.

## Timing
- Stall, flush and forward outputs are combinational from inputs and pend_cnt, valid in the same cycle.
- pend_cnt, stall_cycles and flush_cycles update on the rising clk edge.
- PC write accepted in cycle t:
  - StallF asserted in t, t+1, t+2.
  - FlushD asserted in t..t+3.
  - StallF is released in t+3 so the new PC is fetched the same cycle the writer is in W.
- Load-use: a single stall cycle. The next cycle WA3E is a bubble (FlushE), so ldstall drops without extra state.
- Reset (reset=0):
  - pend_cnt=0, stall_cycles=0, flush_cycles=0, all asynchronously.
  - While reset is low, outputs are forced: FlushD=FlushE=1, StallF=StallD=0, ForwardAE=ForwardBE=00.
  - Reset mid-pending discards the pending PC write.
- First edge after reset release: normal operation.

## Test plan
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=4, RA1D=4 for one cycle -> StallF=StallD=FlushE=1, FlushD=0; stall_cycles=1 after the edge.
- Forwarding priority: RegWriteM=RegWriteW=1, WA3M=WA3W=RA1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=15 -> 00.
- PC write: PCSrcD=1 for one cycle -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles. A second PCSrcD pulse during that window does not restart the counter.
- Branch taken: BranchTakenE=1 together with PCSrcD=1 -> FlushD=FlushE=1, pend_cnt stays 0, flush_cycles increments by 1.
- Reset mid-pending: assert reset at pend_cnt=2 -> counters 0 and FlushD=FlushE=1 while low; after release with idle inputs, all outputs 0.
- Saturation and clear: CNT_W=4 with ldstall held 20 cycles -> stall_cycles=15. cnt_clr=1 together with ldstall -> 0 on the next edge.
